// File: rtl/bcd_countdown_timer.sv
// MM:SS BCD countdown timer with pause/resume, load validation and a
// self-clearing alarm. Every output is registered.
module bcd_countdown_timer #(
  parameter int MINH_MAX    = 5,
  parameter int ALARM_TICKS = 5
) (
  input  logic       CP,
  input  logic       CR,
  input  logic       Tick,
  input  logic       Load,
  input  logic [3:0] LdMinH,
  input  logic [3:0] LdMinL,
  input  logic [3:0] LdSecH,
  input  logic [3:0] LdSecL,
  input  logic       Start,
  input  logic       Stop,
  output logic [3:0] MinH,
  output logic [3:0] MinL,
  output logic [3:0] SecH,
  output logic [3:0] SecL,
  output logic       Running,
  output logic       Done,
  output logic       Alarm,
  output logic       LdErr
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_ALARM = 2'd3
  } state_t;

  localparam int ACW = (ALARM_TICKS < 2) ? 1 : $clog2(ALARM_TICKS);

  state_t           state_q, state_d;
  logic [3:0]       minh_q, minh_d, minl_q, minl_d;
  logic [3:0]       sech_q, sech_d, secl_q, secl_d;
  logic [ACW-1:0]   acnt_q, acnt_d;
  logic             running_q, running_d, done_q, done_d;
  logic             alarm_q, alarm_d, lderr_q, lderr_d;
  logic             ld_valid, cnt_zero, cnt_one;

  // Next-state, digit and pulse logic; priority Load > Stop > Start > Tick.
  always_comb begin
    state_d  = state_q;
    minh_d   = minh_q;
    minl_d   = minl_q;
    sech_d   = sech_q;
    secl_d   = secl_q;
    acnt_d   = acnt_q;
    done_d   = 1'b0;
    lderr_d  = 1'b0;
    ld_valid = (LdMinH <= 4'(MINH_MAX)) && (LdMinL <= 4'd9) &&
               (LdSecH <= 4'd5) && (LdSecL <= 4'd9);
    cnt_zero = (minh_q == 4'd0) && (minl_q == 4'd0) &&
               (sech_q == 4'd0) && (secl_q == 4'd0);
    cnt_one  = (minh_q == 4'd0) && (minl_q == 4'd0) &&
               (sech_q == 4'd0) && (secl_q == 4'd1);

    if (Load && (state_q != S_RUN)) begin
      if (ld_valid) begin
        minh_d  = LdMinH;
        minl_d  = LdMinL;
        sech_d  = LdSecH;
        secl_d  = LdSecL;
        state_d = S_IDLE;
        acnt_d  = '0;
      end else begin
        lderr_d = 1'b1;
      end
    end else if (Stop) begin
      case (state_q)
        S_RUN:   state_d = S_PAUSE;
        S_ALARM: begin
          state_d = S_IDLE;
          acnt_d  = '0;
        end
        default: state_d = state_q;
      endcase
    end else if (Start && ((state_q == S_IDLE) || (state_q == S_PAUSE)) && !cnt_zero) begin
      state_d = S_RUN;
    end else if (Tick) begin
      case (state_q)
        S_RUN: begin
          if (cnt_one) begin
            secl_d  = 4'd0;
            done_d  = 1'b1;
            state_d = S_ALARM;
            acnt_d  = '0;
          end else if (!cnt_zero) begin
            // Borrow ripples upward only while the lower digit is already zero.
            if (secl_q != 4'd0) begin
              secl_d = secl_q - 4'd1;
            end else begin
              secl_d = 4'd9;
              if (sech_q != 4'd0) begin
                sech_d = sech_q - 4'd1;
              end else begin
                sech_d = 4'd5;
                if (minl_q != 4'd0) begin
                  minl_d = minl_q - 4'd1;
                end else begin
                  minl_d = 4'd9;
                  minh_d = minh_q - 4'd1;
                end
              end
            end
          end else begin
            state_d = S_ALARM;
          end
        end
        S_ALARM: begin
          if (acnt_q == ACW'(ALARM_TICKS - 1)) begin
            state_d = S_IDLE;
            acnt_d  = '0;
          end else begin
            acnt_d = acnt_q + ACW'(1);
          end
        end
        default: state_d = state_q;
      endcase
    end else begin
      state_d = state_q;
    end

    running_d = (state_d == S_RUN);
    alarm_d   = (state_d == S_ALARM);
  end

  // State, digit and output registers with synchronous reset.
  always_ff @(posedge CP) begin
    if (CR) begin
      state_q   <= S_IDLE;
      minh_q    <= 4'd0;
      minl_q    <= 4'd0;
      sech_q    <= 4'd0;
      secl_q    <= 4'd0;
      acnt_q    <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      alarm_q   <= 1'b0;
      lderr_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      minh_q    <= minh_d;
      minl_q    <= minl_d;
      sech_q    <= sech_d;
      secl_q    <= secl_d;
      acnt_q    <= acnt_d;
      running_q <= running_d;
      done_q    <= done_d;
      alarm_q   <= alarm_d;
      lderr_q   <= lderr_d;
    end
  end

  assign MinH    = minh_q;
  assign MinL    = minl_q;
  assign SecH    = sech_q;
  assign SecL    = secl_q;
  assign Running = running_q;
  assign Done    = done_q;
  assign Alarm   = alarm_q;
  assign LdErr   = lderr_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for bcd_countdown_timer: a seconds-based reference model
// pushes expected outputs into a scoreboard that is popped after each edge.
module tb_bcd_countdown_timer;

  logic       CP = 1'b0;
  logic       CR, Tick, Load, Start, Stop;
  logic [3:0] LdMinH, LdMinL, LdSecH, LdSecL;
  logic [3:0] MinH, MinL, SecH, SecL;
  logic       Running, Done, Alarm, LdErr;

  int checks   = 0;
  int failures = 0;

  // model state: 0 IDLE, 1 RUN, 2 PAUSE, 3 ALARM
  int m_secs  = 0;
  int m_state = 0;
  int m_acnt  = 0;

  logic [19:0] sb_q[$];

  bcd_countdown_timer #(.MINH_MAX(5), .ALARM_TICKS(5)) dut (
    .CP(CP), .CR(CR), .Tick(Tick), .Load(Load),
    .LdMinH(LdMinH), .LdMinL(LdMinL), .LdSecH(LdSecH), .LdSecL(LdSecL),
    .Start(Start), .Stop(Stop),
    .MinH(MinH), .MinL(MinL), .SecH(SecH), .SecL(SecL),
    .Running(Running), .Done(Done), .Alarm(Alarm), .LdErr(LdErr)
  );

  always #5 CP = ~CP;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, advance the model, compare after the edge.
  task automatic cyc(input string tag, input logic cr, input logic tick, input logic load,
                     input logic start, input logic stop, input logic [15:0] ld);
    logic        done_e, lderr_e;
    logic [19:0] exp_v, obs_v;
    int          s;
    @(negedge CP);
    CR = cr; Tick = tick; Load = load; Start = start; Stop = stop;
    {LdMinH, LdMinL, LdSecH, LdSecL} = ld;
    done_e = 1'b0;
    lderr_e = 1'b0;
    if (cr) begin
      m_secs = 0; m_state = 0; m_acnt = 0;
    end else if (load && m_state != 1) begin
      if (ld[15:12] <= 4'd5 && ld[11:8] <= 4'd9 && ld[7:4] <= 4'd5 && ld[3:0] <= 4'd9) begin
        m_secs  = (int'(ld[15:12]) * 10 + int'(ld[11:8])) * 60 + int'(ld[7:4]) * 10 + int'(ld[3:0]);
        m_state = 0;
        m_acnt  = 0;
      end else begin
        lderr_e = 1'b1;
      end
    end else if (stop) begin
      if (m_state == 1) m_state = 2;
      else if (m_state == 3) begin m_state = 0; m_acnt = 0; end
    end else if (start && (m_state == 0 || m_state == 2) && m_secs != 0) begin
      m_state = 1;
    end else if (tick) begin
      if (m_state == 1) begin
        m_secs = m_secs - 1;
        if (m_secs == 0) begin done_e = 1'b1; m_state = 3; m_acnt = 0; end
      end else if (m_state == 3) begin
        m_acnt = m_acnt + 1;
        if (m_acnt == 5) begin m_state = 0; m_acnt = 0; end
      end
    end
    s = m_secs;
    exp_v = {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10),
             (m_state == 1), done_e, (m_state == 3), lderr_e};
    sb_q.push_back(exp_v);
    @(posedge CP);
    #1;
    obs_v = {MinH, MinL, SecH, SecL, Running, Done, Alarm, LdErr};
    check(tag, {12'd0, obs_v}, {12'd0, sb_q.pop_front()});
  endtask

  int done_cnt;

  initial begin
    // 1: reset with random inputs
    for (int i = 0; i < 2; i++)
      cyc("reset", 1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
    check("reset_digits", {16'd0, MinH, MinL, SecH, SecL}, 32'h0000_0000);
    cyc("start_at_zero", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    check("start_zero_ignored", {31'd0, Running}, 32'd0);

    // 2: 01:02 down to 00:00
    cyc("load_0102", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0102);
    cyc("start", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    done_cnt = 0;
    for (int i = 0; i < 62; i++) begin
      cyc("tick62", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
      if (Done) done_cnt++;
      cyc("gap62", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      if (Done) done_cnt++;
    end
    check("done_once", done_cnt, 32'd1);
    check("alarm_running", {30'd0, Alarm, Running}, 32'd2);

    // 3: borrow across minutes, pause, resume
    cyc("load_1000", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1000);
    cyc("start", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    cyc("tick", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    check("borrow_0959", {16'd0, MinH, MinL, SecH, SecL}, 32'h0000_0959);
    cyc("load_in_run", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0600);
    cyc("stop", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    for (int i = 0; i < 3; i++)
      cyc("tick_paused", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    check("paused_hold", {16'd0, MinH, MinL, SecH, SecL}, 32'h0000_0959);
    cyc("resume", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    cyc("tick", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    check("resume_0958", {16'd0, MinH, MinL, SecH, SecL}, 32'h0000_0958);

    // 4: rejected loads (from PAUSE)
    cyc("stop", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    cyc("bad_sech", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0160);
    check("lderr_sech", {31'd0, LdErr}, 32'd1);
    cyc("bad_minh", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h6000);
    cyc("bad_secl", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h000A);
    cyc("max_5959", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h5959);
    cyc("start", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    cyc("tick", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);

    // 5a: alarm auto-clears on 5th tick
    cyc("stop", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    cyc("load_0002", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0002);
    cyc("start", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 2; i++)
      cyc("tick_to_zero", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 5; i++)
      cyc("alarm_tick", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    check("alarm_autoclear", {31'd0, Alarm}, 32'd0);

    // 5b: alarm acknowledged by Stop after 2 ticks
    cyc("load_0001", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0001);
    cyc("start", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    cyc("tick_to_zero", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 2; i++)
      cyc("alarm_tick", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    cyc("alarm_stop", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    check("alarm_ack", {31'd0, Alarm}, 32'd0);
    // counter must have been cleared: a fresh alarm needs all 5 ticks again
    cyc("load_0001", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0001);
    cyc("start", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    cyc("tick_to_zero", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 4; i++)
      cyc("alarm_tick", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    check("alarm_counter_cleared", {31'd0, Alarm}, 32'd1);
    cyc("load_in_alarm", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0031);

    // 6: Tick+Stop+Start together in RUN, then reset during RUN
    cyc("start", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    cyc("tick", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    cyc("tick_stop_start", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0000);
    check("pause_0030", {15'd0, MinH, MinL, SecH, SecL, Running}, {15'd0, 16'h0030, 1'b0});
    cyc("start", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    cyc("reset_in_run", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
    check("reset_run", {15'd0, MinH, MinL, SecH, SecL, Running}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
